// File: rtl/usb_cmd_responder_pkg.sv
// Shared definitions for the USB command responder: sync bytes, opcodes,
// header field positions, FSM state encoding and a response-header helper.
package usb_cmd_responder_pkg;

  localparam logic [7:0] SYNC_CMD = 8'h5A;
  localparam logic [7:0] SYNC_RSP = 8'hA5;

  localparam logic [3:0] OP_WRITE  = 4'd1;
  localparam logic [3:0] OP_READ   = 4'd2;
  localparam logic [3:0] OP_STREAM = 4'd3;

  // Header layout: [31:24] sync, [23:20] opcode, [19:16] reserved, [15:0] addr/len
  localparam int unsigned SYNC_LSB  = 24;
  localparam int unsigned OP_LSB    = 20;
  localparam int unsigned RSV_LSB   = 16;
  localparam int unsigned FIELD_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_REQ,
    S_RD_HDR,
    S_RD_DATA,
    S_ST_HDR,
    S_ST_DATA
  } state_t;

  function automatic logic [31:0] rsp_header(input logic [3:0] op, input logic [15:0] field);
    return {SYNC_RSP, op, 4'h0, field};
  endfunction

endpackage

// File: rtl/usb_cmd_queue.sv
// Synchronous command FIFO (DEPTH x WIDTH, DEPTH a power of two).
// Ports: i_clk/i_rstn (sync active-low), i_push/i_wdata write side,
// i_pop read side with first-word-fall-through o_rdata, o_full/o_empty,
// o_overflow (push rejected this cycle), o_count occupancy.
module usb_cmd_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign w_pop      = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_push     = i_push && (!o_full || w_pop);
  assign o_overflow = i_push && !w_push;
  assign o_rdata    = r_mem[r_rptr];
  assign o_count    = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/usb_cmd_responder.sv
// Host command parser/responder. Queues host words, decodes WRITE/READ/STREAM
// headers, drives a simple register bus and frames responses to the TX side.
// Ports: sys_clk/resetn (sync active-low); cmd_valid/cmd_data host words;
// rsp_ready/rsp_en/rsp_data response stream; reg_* register bus;
// tdc_valid/tdc_data/tdc_ready sample stream; err_cnt/drop_cnt saturating.
module usb_cmd_responder
  import usb_cmd_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CMDQ_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  sys_clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  rsp_ready,
  output logic                  rsp_en,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  output logic [15:0]           reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  tdc_valid,
  input  logic [DATA_WIDTH-1:0] tdc_data,
  output logic                  tdc_ready,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);
  localparam int unsigned QCW = $clog2(CMDQ_DEPTH) + 1;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] w_q_head;
  logic                  w_q_empty, w_q_full, w_q_ovf;
  logic [QCW-1:0]        w_q_count;
  logic                  w_pop, w_hdr_ok, w_bad, w_wr_latch, w_xfer;
  logic                  w_rsp_en, w_tdc_ready;
  logic [DATA_WIDTH-1:0] w_rsp_data;
  logic [31:0]           w_rsp_hdr;
  logic                  w_unused;

  logic [3:0]            r_op;
  logic [15:0]           r_addr;
  logic [15:0]           r_remaining;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_wr_stb;
  logic                  r_rd_cap;
  logic [CNT_WIDTH-1:0]  r_err;
  logic [CNT_WIDTH-1:0]  r_drop;

  usb_cmd_queue #(
    .DEPTH (CMDQ_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_queue (
    .i_clk      (sys_clk),
    .i_rstn     (resetn),
    .i_push     (cmd_valid),
    .i_wdata    (cmd_data),
    .i_pop      (w_pop),
    .o_rdata    (w_q_head),
    .o_full     (w_q_full),
    .o_empty    (w_q_empty),
    .o_overflow (w_q_ovf),
    .o_count    (w_q_count)
  );

  assign w_unused  = &{1'b0, w_q_full, w_q_count};
  assign w_rsp_hdr = rsp_header(r_op, r_addr);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_hdr_ok    = 1'b0;
    w_bad       = 1'b0;
    w_wr_latch  = 1'b0;
    w_xfer      = 1'b0;
    w_rsp_en    = 1'b0;
    w_rsp_data  = '0;
    w_tdc_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_q_empty) begin
          w_pop = 1'b1;
          if (w_q_head[SYNC_LSB +: 8] != SYNC_CMD || w_q_head[RSV_LSB +: 4] != 4'h0) begin
            w_bad = 1'b1;
          end else begin
            w_hdr_ok = 1'b1;
            case (w_q_head[OP_LSB +: 4])
              OP_WRITE:  w_state_nxt = S_WR_DATA;
              OP_READ:   w_state_nxt = S_RD_REQ;
              OP_STREAM: w_state_nxt = S_ST_HDR;
              default: begin
                w_hdr_ok = 1'b0;
                w_bad    = 1'b1;
              end
            endcase
          end
        end
      end
      // Data is popped and registered first; the strobe cycle follows so
      // reg_wdata and reg_wr_en come out of flops together.
      S_WR_DATA: begin
        if (r_wr_stb) begin
          w_state_nxt = S_WR_ACK;
        end else if (!w_q_empty) begin
          w_pop      = 1'b1;
          w_wr_latch = 1'b1;
        end
      end
      S_WR_ACK: begin
        if (rsp_ready) begin
          w_rsp_en    = 1'b1;
          w_rsp_data  = w_rsp_hdr;
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_REQ: w_state_nxt = S_RD_HDR;
      S_RD_HDR: begin
        if (rsp_ready) begin
          w_rsp_en    = 1'b1;
          w_rsp_data  = w_rsp_hdr;
          w_state_nxt = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (rsp_ready) begin
          w_rsp_en    = 1'b1;
          w_rsp_data  = r_rdata;
          w_state_nxt = S_IDLE;
        end
      end
      S_ST_HDR: begin
        if (rsp_ready) begin
          w_rsp_en    = 1'b1;
          w_rsp_data  = w_rsp_hdr;
          w_state_nxt = (r_addr == 16'd0) ? S_IDLE : S_ST_DATA;
        end
      end
      S_ST_DATA: begin
        w_tdc_ready = rsp_ready;
        if (rsp_ready && tdc_valid) begin
          w_xfer     = 1'b1;
          w_rsp_en   = 1'b1;
          w_rsp_data = tdc_data;
          if (r_remaining == 16'd1) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_wr_stb    <= 1'b0;
      r_rd_cap    <= 1'b0;
      r_err       <= '0;
      r_drop      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_stb <= w_wr_latch;
      // High exactly on the RD_HDR entry cycle, when reg_rdata is valid.
      r_rd_cap <= (r_state == S_RD_REQ);
      if (w_hdr_ok) begin
        r_op   <= w_q_head[OP_LSB +: 4];
        r_addr <= w_q_head[FIELD_LSB +: 16];
      end
      if (w_wr_latch) r_wdata <= w_q_head;
      if (r_rd_cap)   r_rdata <= reg_rdata;
      if (r_state == S_ST_HDR && rsp_ready) r_remaining <= r_addr;
      else if (w_xfer)                      r_remaining <= r_remaining - 16'd1;
      if (w_bad && r_err != '1)    r_err  <= r_err + 1'b1;
      if (w_q_ovf && r_drop != '1) r_drop <= r_drop + 1'b1;
    end
  end

  assign rsp_en    = w_rsp_en;
  assign rsp_data  = w_rsp_data;
  assign reg_wr_en = r_wr_stb;
  assign reg_rd_en = (r_state == S_RD_REQ);
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign tdc_ready = w_tdc_ready;
  assign err_cnt   = r_err;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_usb_cmd_responder.sv
// Scoreboard bench for usb_cmd_responder: stimulus tasks push expected
// responses/register writes into queues; monitor processes pop and compare.
module tb_usb_cmd_responder;

  localparam int unsigned QDEPTH = 4;

  logic        sys_clk   = 1'b0;
  logic        resetn    = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data  = '0;
  logic        rsp_ready = 1'b1;
  logic [31:0] reg_rdata = '0;
  logic        tdc_valid = 1'b0;
  logic [31:0] tdc_data  = '0;
  logic        rsp_en, reg_wr_en, reg_rd_en, tdc_ready;
  logic [31:0] rsp_data, reg_wdata;
  logic [15:0] reg_addr;
  logic [7:0]  err_cnt, drop_cnt;

  usb_cmd_responder #(
    .DATA_WIDTH (32),
    .CMDQ_DEPTH (QDEPTH),
    .CNT_WIDTH  (8)
  ) dut (
    .sys_clk   (sys_clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .rsp_ready (rsp_ready),
    .rsp_en    (rsp_en),
    .rsp_data  (rsp_data),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .tdc_valid (tdc_valid),
    .tdc_data  (tdc_data),
    .tdc_ready (tdc_ready),
    .err_cnt   (err_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard and reference model state
  logic [31:0] exp_rsp[$];
  logic [47:0] exp_wr[$];
  int unsigned rsp_log[$];
  bit [31:0]   model_mem [bit [15:0]];
  int unsigned model_tdc_idx = 0;
  int unsigned model_err = 0;
  int unsigned model_drop = 0;

  // Environment state
  bit [31:0]   slave_mem [bit [15:0]];
  bit          rd_pend = 0;
  logic [15:0] rd_addr = '0;
  bit          tdc_hs = 0;
  int unsigned tdc_idx = 0;
  int unsigned tdc_mode = 0;   // 0 always valid, 1 alternating, 2 random
  bit          bp_random = 0;
  bit          tdc_seen = 0;
  int unsigned last_wr_cyc = 0;
  int unsigned last_rd_cyc = 0;

  function automatic logic [31:0] smp(input int unsigned i);
    return i * 32'h9E3779B9 + 32'h0BADF00D;
  endfunction

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {a, ~a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %08h required %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge
  always @(negedge sys_clk) begin
    tdc_hs = tdc_valid && tdc_ready;
    if (tdc_ready) tdc_seen = 1;
    if (rsp_en) begin
      rsp_log.push_back(cyc);
      check("rsp_en_needs_ready", 32'(rsp_ready), 32'd1);
      if (exp_rsp.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: actual %08h required no word", rsp_data);
      end else begin
        check("rsp_word", rsp_data, exp_rsp.pop_front());
      end
    end
    if (reg_wr_en) begin
      last_wr_cyc = cyc;
      slave_mem[reg_addr] = reg_wdata;
      if (exp_wr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_wr: actual addr %04h data %08h required no write", reg_addr, reg_wdata);
      end else begin
        logic [47:0] e;
        e = exp_wr.pop_front();
        check("wr_addr", 32'(reg_addr), 32'(e[47:32]));
        check("wr_data", reg_wdata, e[31:0]);
      end
    end
    if (reg_rd_en) begin
      last_rd_cyc = cyc;
      rd_pend = 1;
      rd_addr = reg_addr;
    end
  end

  // Register slave, TDC source and random backpressure
  always @(posedge sys_clk) begin
    #1;
    if (rd_pend) reg_rdata = slave_mem.exists(rd_addr) ? slave_mem[rd_addr] : dflt(rd_addr);
    else         reg_rdata = $urandom;
    rd_pend = 0;
    if (tdc_hs) tdc_idx++;
    tdc_hs = 0;
    case (tdc_mode)
      0:       tdc_valid = 1'b1;
      1:       tdc_valid = ~tdc_valid;
      default: tdc_valid = ($urandom_range(0, 3) != 0);
    endcase
    tdc_data = tdc_valid ? smp(tdc_idx) : $urandom;
    if (bp_random) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    cmd_valid = 1'b1;
    cmd_data  = w;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = $urandom;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input int unsigned gap);
    exp_rsp.push_back({8'hA5, 4'h1, 4'h0, a});
    exp_wr.push_back({a, d});
    model_mem[a] = d;
    push_word({8'h5A, 4'h1, 4'h0, a});
    repeat (gap) tick();
    push_word(d);
  endtask

  task automatic do_read(input logic [15:0] a);
    exp_rsp.push_back({8'hA5, 4'h2, 4'h0, a});
    exp_rsp.push_back(model_mem.exists(a) ? model_mem[a] : dflt(a));
    push_word({8'h5A, 4'h2, 4'h0, a});
  endtask

  task automatic do_stream(input logic [15:0] len);
    exp_rsp.push_back({8'hA5, 4'h3, 4'h0, len});
    for (int unsigned i = 0; i < len; i++) begin
      exp_rsp.push_back(smp(model_tdc_idx));
      model_tdc_idx++;
    end
    push_word({8'h5A, 4'h3, 4'h0, len});
  endtask

  task automatic do_bad(input logic [31:0] w);
    if (model_err < 255) model_err++;
    push_word(w);
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while ((exp_rsp.size() != 0 || exp_wr.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_rsp.size() != 0 || exp_wr.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d responses and %0d writes outstanding, required 0", exp_rsp.size(), exp_wr.size());
      exp_rsp.delete();
      exp_wr.delete();
    end
    repeat (3) tick();
  endtask

  task automatic wait_rsp(input int unsigned count, input int unsigned budget, input string name);
    int unsigned n = 0;
    while (rsp_log.size() < count && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(rsp_log.size() >= count), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    #1;
    check({tag, "_rsp_en"},    32'(rsp_en),    32'd0);
    check({tag, "_rsp_data"},  rsp_data,       32'd0);
    check({tag, "_reg_wr_en"}, 32'(reg_wr_en), 32'd0);
    check({tag, "_reg_rd_en"}, 32'(reg_rd_en), 32'd0);
    check({tag, "_reg_addr"},  32'(reg_addr),  32'd0);
    check({tag, "_reg_wdata"}, reg_wdata,      32'd0);
    check({tag, "_tdc_ready"}, 32'(tdc_ready), 32'd0);
    check({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
    check({tag, "_drop_cnt"},  32'(drop_cnt),  32'd0);
  endtask

  function automatic logic [31:0] bad_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 2))
      0: if (w[31:24] == 8'h5A) w[31:24] = 8'h3C;
      1: begin
        w[31:24] = 8'h5A;
        w[19:16] = 4'h0;
        if (w[23:20] inside {4'd1, 4'd2, 4'd3}) w[23:20] = 4'hF;
      end
      default: begin
        w[31:24] = 8'h5A;
        w[23:20] = 4'($urandom_range(1, 3));
        if (w[19:16] == 4'h0) w[19:16] = 4'h8;
      end
    endcase
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] burst [6];
    int unsigned t0;

    // Reset state
    repeat (3) tick();
    check_zero("reset");
    resetn = 1'b1;
    tick();

    // Write then read with latency checks
    rsp_log.delete();
    t0 = cyc;
    do_write(16'h0012, 32'hDEADBEEF, 0);
    drain(100);
    check("wr_en_latency", last_wr_cyc - t0, 32'd3);
    check("wr_ack_latency", (rsp_log.size() > 0) ? rsp_log[0] - t0 : 32'hFFFFFFFF, 32'd4);
    rsp_log.delete();
    t0 = cyc;
    do_read(16'h0012);
    drain(100);
    check("rd_en_latency", last_rd_cyc - t0, 32'd2);
    check("rd_hdr_latency", (rsp_log.size() > 0) ? rsp_log[0] - t0 : 32'hFFFFFFFF, 32'd3);
    check("rd_data_latency", (rsp_log.size() > 1) ? rsp_log[1] - t0 : 32'hFFFFFFFF, 32'd4);
    check("reg_addr_hold", 32'(reg_addr), 32'h0000_0012);
    check("reg_wdata_hold", reg_wdata, 32'hDEADBEEF);

    // Stream of 3 with toggling tdc_valid and a 2-cycle rsp_ready stall
    tdc_mode = 1;
    rsp_log.delete();
    do_stream(16'd3);
    wait_rsp(2, 50, "stream_started");
    rsp_ready = 1'b0;
    #1 check("stall_no_en_0", 32'(rsp_en), 32'd0);
    tick();
    #1 check("stall_no_en_1", 32'(rsp_en), 32'd0);
    tick();
    rsp_ready = 1'b1;
    drain(100);
    check("stream3_words", rsp_log.size(), 32'd4);

    // Zero-length stream
    tdc_mode = 0;
    tdc_seen = 0;
    rsp_log.delete();
    do_stream(16'd0);
    drain(100);
    repeat (3) tick();
    check("zero_len_words", rsp_log.size(), 32'd1);
    check("zero_len_tdc_ready", 32'(tdc_seen), 32'd0);

    // Malformed headers followed by a valid READ
    do_bad(32'h1234_5678);
    do_bad(32'h5A90_0000);
    do_read(16'h0077);
    drain(100);
    check("err_cnt_after_bad", 32'(err_cnt), model_err);

    // Overflow while the FSM is stalled on a READ response
    rsp_ready = 1'b0;
    do_read(16'h0012);
    repeat (4) tick();
    burst = '{32'h5A10_0040, 32'h1111_2222, 32'h5A20_0040, 32'h5A30_0000, 32'h5A20_0041, 32'h5A20_0042};
    exp_rsp.push_back(32'hA510_0040);
    exp_wr.push_back({16'h0040, 32'h1111_2222});
    model_mem[16'h0040] = 32'h1111_2222;
    exp_rsp.push_back(32'hA520_0040);
    exp_rsp.push_back(32'h1111_2222);
    exp_rsp.push_back(32'hA530_0000);
    for (int k = 0; k < 6; k++) begin
      cmd_valid = 1'b1;
      cmd_data  = burst[k];
      tick();
      if (k + 1 > QDEPTH) model_drop++;
      check("drop_during_burst", 32'(drop_cnt), model_drop);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain(200);
    check("drop_cnt_final", 32'(drop_cnt), model_drop);

    // Reset in the middle of a stream
    rsp_log.delete();
    do_stream(16'd16);
    wait_rsp(4, 100, "long_stream_started");
    resetn = 1'b0;
    tick();
    #1;
    exp_rsp.delete();
    model_tdc_idx = tdc_idx;
    model_err = 0;
    model_drop = 0;
    check_zero("mid_stream_reset");
    resetn = 1'b1;
    tick();
    do_read(16'h0012);
    drain(100);

    // Randomized commands against the reference model
    bp_random = 1;
    tdc_mode = 2;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: do_write(16'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2));
        1: do_read(16'($urandom_range(0, 9)));
        2: do_stream(16'($urandom_range(0, 6)));
        default: do_bad(bad_word());
      endcase
      drain(300);
      check("rand_err_cnt", 32'(err_cnt), model_err);
    end
    bp_random = 0;
    rsp_ready = 1'b1;
    tick();
    check("final_drop_cnt", 32'(drop_cnt), model_drop);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_cmd_responder.md
# usb_cmd_responder

Single-clock command parser and responder on the `sys_clk` side of the USB bridge. It consumes 32-bit host command words from the USB transceiver's user-side receive output and executes register writes and reads on a simple register bus. It also streams TDC sample words back, and frames every response into the transceiver's user-side transmit input. It is the far end of the host↔FPGA command protocol.

## Interface
- `DATA_WIDTH`, 32, command/response word width (fixed 32; other values unsupported)
- `CMDQ_DEPTH`, 4, command queue depth (power of two, ≥2)
- `CNT_WIDTH`, 8, width of error/drop counters
- `sys_clk` in 1: sole clock
- `resetn` in 1: synchronous, active-low reset
- `cmd_valid` in 1: host word present; the word is consumed every cycle it is high; no backpressure exists
- `cmd_data` in 32: host word
- `rsp_ready` in 1: transmit FIFO not almost-full
- `rsp_en` out 1: write strobe, one word per cycle
- `rsp_data` out 32: response word
- `reg_wr_en` out 1: one-cycle register write strobe
- `reg_rd_en` out 1: one-cycle register read strobe
- `reg_addr` out 16: register address
- `reg_wdata` out 32: write data
- `reg_rdata` in 32: read data, valid exactly 1 cycle after `reg_rd_en`
- `tdc_valid` in 1: sample available
- `tdc_data` in 32: sample
- `tdc_ready` out 1: sample accepted when `tdc_valid & tdc_ready`
- `err_cnt` out CNT_WIDTH: saturating count of malformed headers
- `drop_cnt` out CNT_WIDTH: saturating count of words lost to queue overflow

## Operation
- Header format: [31:24] = 8'h5A sync, [23:20] opcode, [19:16] = 0, [15:0] addr or length. Opcodes: 1 = WRITE, 2 = READ, 3 = STREAM.
- Response header format: {8'hA5, opcode, 4'h0, addr/len echo}.
- Every `cmd_valid` word is pushed into the command queue. On a push when the queue is full, the word is dropped and `drop_cnt` increments. Push and pop in the same cycle on a full queue succeed.
- FSM states:
  - IDLE: pop the head word. Bad sync, nonzero [19:16] or an unknown opcode → `err_cnt`++, stay in IDLE. WRITE → WR_DATA. READ → RD_REQ. STREAM → ST_HDR.
  - WR_DATA: wait for a queued word, pop it as raw data (no sync check). Drive `reg_wr_en` for 1 cycle with the latched addr → WR_ACK.
  - WR_ACK: emit the response header when `rsp_ready` → IDLE.
  - RD_REQ: `reg_rd_en` for 1 cycle → RD_HDR.
  - RD_HDR: capture `reg_rdata` on entry cycle; emit header when `rsp_ready` → RD_DATA.
  - RD_DATA: emit captured data when `rsp_ready` → IDLE.
  - ST_HDR: emit header when `rsp_ready`; len = 0 → IDLE, else → ST_DATA with remaining = len.
  - ST_DATA: `tdc_ready = rsp_ready`; on each transfer, `rsp_en` = 1, `rsp_data = tdc_data`, remaining−−; transfer with remaining = 1 → IDLE.
- `rsp_en` is never asserted while `rsp_ready` = 0. `tdc_ready` = 0 outside ST_DATA.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (resetn = 0 at a clock edge):
  - all outputs 0
  - queue empty
  - FSM IDLE
  - counters 0
- Reset mid-operation abandons the response with no trailer. The host recovers by resync.
- Latency from `cmd_valid` to queue visibility: 1 cycle. IDLE decodes the head word in the cycle after the push.
- READ: header word enters the queue at cycle t. `reg_rd_en` at t+2. Header `rsp_en` at t+3 and data at t+4 with `rsp_ready` held high.
- WRITE: data word lands 1 cycle after the header. `reg_wr_en` 2 cycles later, ack 1 cycle after that.
- STREAM: one word per cycle at full throughput. Stalls on `rsp_ready` = 0 or `tdc_valid` = 0 lose nothing.
- `reg_addr`/`reg_wdata` are stable from the strobe cycle until the next command.

## Structure
- Shared package holds:
  - sync bytes 8'h5A/8'hA5
  - opcode constants
  - state encoding
  - header field positions
- Sub-module `usb_cmd_queue`: synchronous FIFO, CMDQ_DEPTH × 32, with full/empty, an overflow pulse, and an occupancy count. The top level holds the FSM, the response mux and the counters.

## Test plan
- Write then read: push 5A10_0012, DEAD_BEEF, 5A20_0012, with the model register file returning the written value. Expected:
  - `reg_wr_en` with addr 0x0012, data DEADBEEF
  - response A510_0012, A520_0012, DEADBEEF
- Stream of 3 with gaps: header 5A30_0003, `tdc_valid` toggling, and `rsp_ready` low for 2 cycles mid-burst. Expected: A530_0003 followed by exactly 3 samples in order, and no `rsp_en` while `rsp_ready` = 0.
- Zero-length stream: 5A30_0000 → only A530_0000, and `tdc_ready` never rises.
- Malformed headers: 1234_5678, then 5A90_0000, then a valid READ. Expected: `err_cnt` = 2 and a correct read response.
- Overflow: hold `rsp_ready` = 0 during a READ while pushing 6 more words back-to-back. Expected: `drop_cnt` increments for each word pushed while the queue is full, and queued commands run in order after release.
- Reset mid-stream: deassert `resetn` during ST_DATA. Expected: next cycle all outputs 0 and `err_cnt`/`drop_cnt` cleared; a subsequent READ responds normally.
